// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM states, default width,
// and the signed-overflow rule applied to the operand and result sign bits.
package full_adder_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Overflow happens when the operand signs differ and the result sign differs from the minuend.
    function automatic logic ovf_calc(input logic a_msb, input logic b_msb, input logic d_msb);
        return (a_msb != b_msb) && (d_msb != a_msb);
    endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// Operand/result handshake bundle for the serial subtractor; the producer side
// drives operands and accepts results, the subtractor side does the reverse.
interface serial_subtractor_if
    import full_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             ovf;

    modport master (
        output in_valid, a, b, bin, out_ready,
        input  in_ready, out_valid, diff, bout, ovf
    );

    modport slave (
        input  in_valid, a, b, bin, out_ready,
        output in_ready, out_valid, diff, bout, ovf
    );

endinterface

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit combinational full subtractor used as the per-cycle step of the
// serial datapath.
module full_subtractor (
    input  logic a_i,
    input  logic b_i,
    input  logic bin_i,
    output logic diff_o,
    output logic bout_o
);

    assign diff_o = a_i ^ b_i ^ bin_i;
    assign bout_o = (~a_i & b_i) | (~(a_i ^ b_i) & bin_i);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial a - b - bin: operands are shifted out LSB first through a single
// full subtractor; the result is presented with a valid/ready handshake.
module serial_subtractor
    import full_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk_i,
    input  logic             reset_n_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             bin_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] diff_o,
    output logic             bout_o,
    output logic             ovf_o
);

    localparam int              CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_res;
    logic [WIDTH-1:0] r_diff;
    logic [CNT_W-1:0] r_cnt;
    logic             r_br;
    logic             r_a_msb;
    logic             r_b_msb;
    logic             r_fin;
    logic             r_bout;
    logic             r_ovf;
    logic             r_in_ready;
    logic             r_out_valid;

    logic             w_d;
    logic             w_bo;

    full_subtractor u_fs (
        .a_i    (r_a[0]),
        .b_i    (r_b[0]),
        .bin_i  (r_br),
        .diff_o (w_d),
        .bout_o (w_bo)
    );

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state     <= IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_res       <= '0;
            r_diff      <= '0;
            r_cnt       <= '0;
            r_br        <= 1'b0;
            r_a_msb     <= 1'b0;
            r_b_msb     <= 1'b0;
            r_fin       <= 1'b0;
            r_bout      <= 1'b0;
            r_ovf       <= 1'b0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_in_ready <= 1'b1;
                    if (in_valid_i && r_in_ready) begin
                        r_a        <= a_i;
                        r_b        <= b_i;
                        r_br       <= bin_i;
                        r_a_msb    <= a_i[WIDTH-1];
                        r_b_msb    <= b_i[WIDTH-1];
                        r_cnt      <= '0;
                        r_fin      <= 1'b0;
                        r_in_ready <= 1'b0;
                        r_state    <= BUSY;
                    end
                end
                BUSY: begin
                    // WIDTH shift cycles, then one cycle to publish the finished result.
                    if (!r_fin) begin
                        r_a   <= r_a >> 1;
                        r_b   <= r_b >> 1;
                        r_br  <= w_bo;
                        r_res <= {w_d, r_res[WIDTH-1:1]};
                        if (r_cnt == LAST) begin
                            r_fin <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end else begin
                        r_diff      <= r_res;
                        r_bout      <= r_br;
                        r_ovf       <= ovf_calc(r_a_msb, r_b_msb, r_res[WIDTH-1]);
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready_i) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_in_ready  <= 1'b0;
                    r_out_valid <= 1'b0;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready_o  = r_in_ready;
    assign out_valid_o = r_out_valid;
    assign diff_o      = r_diff;
    assign bout_o      = r_bout;
    assign ovf_o       = r_ovf;

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor at WIDTH = 8.
module tb_serial_subtractor;

    localparam int W = 8;

    typedef struct packed {
        logic [W-1:0] diff;
        logic         bout;
        logic         ovf;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;
    exp_t sb_q[$];

    always #5 clk = ~clk;

    serial_subtractor_if #(.WIDTH(W)) bus ();

    serial_subtractor #(.WIDTH(W)) dut (
        .clk_i       (clk),
        .reset_n_i   (rst_n),
        .in_valid_i  (bus.in_valid),
        .in_ready_o  (bus.in_ready),
        .a_i         (bus.a),
        .b_i         (bus.b),
        .bin_i       (bus.bin),
        .out_valid_o (bus.out_valid),
        .out_ready_i (bus.out_ready),
        .diff_o      (bus.diff),
        .bout_o      (bus.bout),
        .ovf_o       (bus.ovf)
    );

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
        exp_t e;
        int   ud;
        int   sd;
        ud     = int'(a) - int'(b) - int'(bin);
        sd     = int'($signed(a)) - int'($signed(b)) - int'(bin);
        e.diff = ud[W-1:0];
        e.bout = (ud < 0);
        e.ovf  = (sd > (2 ** (W - 1)) - 1) || (sd < -(2 ** (W - 1)));
        return e;
    endfunction

    function automatic exp_t pop_exp();
        exp_t e;
        e = '0;
        if (sb_q.size() > 0) e = sb_q.pop_front();
        return e;
    endfunction

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
        int t;
        t = 0;
        @(negedge clk);
        bus.a = a;
        bus.b = b;
        bus.bin = bin;
        bus.in_valid = 1'b1;
        while (!bus.in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!bus.in_ready) begin
            n_vec++;
            n_err++;
            $display("FAIL send_timeout in_ready=%b required=1", bus.in_ready);
        end else begin
            sb_q.push_back(model(a, b, bin));
        end
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_out(output int c);
        c = 0;
        while (!bus.out_valid && c < 40) begin
            @(negedge clk);
            c++;
        end
    endtask

    task automatic release_out();
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_vec++;
        if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_ctrl in_ready=%b out_valid=%b required=0/0", bus.in_ready, bus.out_valid);
        end
        n_vec++;
        if (bus.diff !== '0 || bus.bout !== 1'b0 || bus.ovf !== 1'b0) begin
            n_err++;
            $display("FAIL reset_data diff=%h bout=%b ovf=%b required=00/0/0", bus.diff, bus.bout, bus.ovf);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_vec++;
        if (bus.in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_release in_ready=%b required=1", bus.in_ready);
        end
    endtask

    task automatic test_basic();
        logic [W-1:0] ta [5] = '{8'h05, 8'h00, 8'h00, 8'h80, 8'h7F};
        logic [W-1:0] tb [5] = '{8'h03, 8'h01, 8'h00, 8'h01, 8'hFF};
        logic         tc [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        exp_t e;
        int   c;
        for (int i = 0; i < 5; i++) begin
            send(ta[i], tb[i], tc[i]);
            wait_out(c);
            e = pop_exp();
            n_vec++;
            if (c !== W + 1) begin
                n_err++;
                $display("FAIL basic_latency[%0d] cycles=%0d required=%0d", i, c, W + 1);
            end
            n_vec++;
            if (bus.diff !== e.diff || bus.bout !== e.bout || bus.ovf !== e.ovf) begin
                n_err++;
                $display("FAIL basic_result[%0d] diff=%h bout=%b ovf=%b required=%h/%b/%b",
                         i, bus.diff, bus.bout, bus.ovf, e.diff, e.bout, e.ovf);
            end
            release_out();
            n_vec++;
            if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
                n_err++;
                $display("FAIL basic_release[%0d] out_valid=%b in_ready=%b required=0/1",
                         i, bus.out_valid, bus.in_ready);
            end
        end
    endtask

    task automatic test_backpressure();
        exp_t e;
        int   c;
        int   bad;
        send(8'hC3, 8'h5A, 1'b1);
        wait_out(c);
        e = pop_exp();
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.diff !== e.diff ||
                bus.bout !== e.bout || bus.ovf !== e.ovf) bad++;
            @(negedge clk);
        end
        n_vec++;
        if (bad != 0) begin
            n_err++;
            $display("FAIL backpressure_hold unstable_cycles=%0d required=0 (diff=%h required=%h)",
                     bad, bus.diff, e.diff);
        end
        release_out();
        n_vec++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL backpressure_release out_valid=%b in_ready=%b required=0/1",
                     bus.out_valid, bus.in_ready);
        end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        int   c;
        int   seen;
        send(8'h33, 8'h11, 1'b0);
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        sb_q.delete();
        n_vec++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL reset_mid_async out_valid=%b in_ready=%b required=0/0", bus.out_valid, bus.in_ready);
        end
        repeat (3) @(negedge clk);
        n_vec++;
        if (bus.in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL reset_mid_held in_ready=%b required=0", bus.in_ready);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_vec++;
        if (bus.in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_mid_release in_ready=%b required=1", bus.in_ready);
        end
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (bus.out_valid !== 1'b0) seen++;
        end
        n_vec++;
        if (seen != 0) begin
            n_err++;
            $display("FAIL reset_mid_abandon out_valid_cycles=%0d required=0", seen);
        end
        send(8'h10, 8'h01, 1'b0);
        wait_out(c);
        e = pop_exp();
        n_vec++;
        if (bus.diff !== 8'h0F || bus.diff !== e.diff || bus.bout !== e.bout || bus.ovf !== e.ovf) begin
            n_err++;
            $display("FAIL reset_mid_next diff=%h bout=%b ovf=%b required=0f/%b/%b",
                     bus.diff, bus.bout, bus.ovf, e.bout, e.ovf);
        end
        release_out();
    endtask

    task automatic test_operand_change();
        exp_t e;
        int   c;
        send(8'hA5, 8'h3C, 1'b1);
        c = 0;
        while (!bus.out_valid && c < 40) begin
            bus.a = ~bus.a;
            bus.b = bus.b ^ 8'h5A;
            bus.bin = ~bus.bin;
            bus.in_valid = 1'b1;
            @(negedge clk);
            c++;
        end
        bus.in_valid = 1'b0;
        e = pop_exp();
        n_vec++;
        if (c !== W + 1) begin
            n_err++;
            $display("FAIL operand_change_latency cycles=%0d required=%0d", c, W + 1);
        end
        n_vec++;
        if (bus.diff !== e.diff || bus.bout !== e.bout || bus.ovf !== e.ovf) begin
            n_err++;
            $display("FAIL operand_change_result diff=%h bout=%b ovf=%b required=%h/%b/%b",
                     bus.diff, bus.bout, bus.ovf, e.diff, e.bout, e.ovf);
        end
        release_out();
    endtask

    task automatic test_back_to_back();
        exp_t         e;
        int           c;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic         rc;
        for (int i = 0; i < 10; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rc = 1'($urandom);
            send(ra, rb, rc);
            wait_out(c);
            e = pop_exp();
            n_vec++;
            if (c !== W + 1 || bus.diff !== e.diff || bus.bout !== e.bout || bus.ovf !== e.ovf) begin
                n_err++;
                $display("FAIL b2b[%0d] a=%h b=%h bin=%b cycles=%0d diff=%h bout=%b ovf=%b required=%0d/%h/%b/%b",
                         i, ra, rb, rc, c, bus.diff, bus.bout, bus.ovf, W + 1, e.diff, e.bout, e.ovf);
            end
            release_out();
        end
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.bin       = 1'b0;
        bus.out_ready = 1'b0;
        test_reset();
        test_basic();
        test_backpressure();
        test_reset_mid();
        test_operand_change();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
